// File: rtl/ram_rd_resp_stream.sv
// Read-response streamer for port 0 of a banked 1RW+1W RAM.
// Latency: request accept at N -> response valid at N+2 (N+1 with the bypass build).
// Backpressure: requests stall on credit; accepted reads always have a FIFO slot reserved.
//
// Ports:
//   clk_i, reset_i                      clock, asynchronous active-high reset
//   rd_req_val_i/_addr_i/_tag_i/_rdy_o  read request stream
//   ram_v0_o, ram_w0_o, ram_addr0_o     RAM port-0 controls (write enable tied low)
//   ram_r0_data_i                       RAM port-0 read data, one cycle after issue
//   rd_resp_val_o/_data_o/_tag_o/_rdy_i response stream
//   occupancy_o                         queued responses plus the read in flight
//
// Optional build macro: RAM_RD_RESP_BYPASS_EN. When defined, a response whose
// read data arrives while the FIFO is empty is presented straight from the
// RAM in the same cycle, skipping the FIFO if the consumer takes it.
module ram_rd_resp_stream #(
    parameter int width_p     = 64,
    parameter int els_p       = 512,
    parameter int tag_width_p = 4,
    parameter int fifo_els_p  = 4,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int occ_width_lp  = $clog2(fifo_els_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     rd_req_val_i,
    input  logic [addr_width_lp-1:0] rd_req_addr_i,
    input  logic [tag_width_p-1:0]   rd_req_tag_i,
    output logic                     rd_req_rdy_o,

    output logic                     ram_v0_o,
    output logic                     ram_w0_o,
    output logic [addr_width_lp-1:0] ram_addr0_o,
    input  logic [width_p-1:0]       ram_r0_data_i,

    output logic                     rd_resp_val_o,
    output logic [width_p-1:0]       rd_resp_data_o,
    output logic [tag_width_p-1:0]   rd_resp_tag_o,
    input  logic                     rd_resp_rdy_i,

    output logic [occ_width_lp-1:0]  occupancy_o
);

    localparam int ptr_width_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam logic [occ_width_lp-1:0] fifo_els_lp  = occ_width_lp'(fifo_els_p);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp  = ptr_width_lp'(fifo_els_p - 1);

    // Response storage
    logic [width_p-1:0]     data_mem [fifo_els_p];
    logic [tag_width_p-1:0] tag_mem  [fifo_els_p];

    logic [ptr_width_lp-1:0] wr_ptr_r;
    logic [ptr_width_lp-1:0] rd_ptr_r;
    logic [occ_width_lp-1:0] count_r;

    // The read issued last cycle and its tag
    logic                    inflight_r;
    logic [tag_width_p-1:0]  tag_r;

    logic                    accept;
    logic                    push;
    logic                    pop_fifo;
    logic                    bypass_act;
    logic                    bypass_pop;
    logic                    fifo_nonempty;
    logic [occ_width_lp-1:0] occ;

    // Pointers wrap at the FIFO depth, which need not be a power of two.
    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign fifo_nonempty = (count_r != '0);
    assign pop_fifo      = fifo_nonempty & rd_resp_rdy_i;

`ifdef RAM_RD_RESP_BYPASS_EN
    assign bypass_act    = ~fifo_nonempty & inflight_r;
`else
    assign bypass_act    = 1'b0;
`endif
    assign bypass_pop    = bypass_act & rd_resp_rdy_i;

    // A bypassed response that the consumer takes never occupies a slot.
    assign push          = inflight_r & ~bypass_pop;

    // Credits: every accepted read reserves a slot, so the in-flight read
    // counts against the FIFO depth. A pop this cycle frees a slot in time
    // for a read accepted now, whose data lands two edges later at the earliest.
    assign occ           = count_r + occ_width_lp'(inflight_r);
    assign rd_req_rdy_o  = ~reset_i &
                           ((occ < fifo_els_lp) |
                            ((occ == fifo_els_lp) & (pop_fifo | bypass_pop)));
    assign accept        = rd_req_val_i & rd_req_rdy_o;

    assign ram_v0_o      = accept;
    assign ram_w0_o      = 1'b0;
    assign ram_addr0_o   = rd_req_addr_i;

    assign rd_resp_val_o  = fifo_nonempty | bypass_act;
    assign rd_resp_data_o = bypass_act ? ram_r0_data_i : data_mem[rd_ptr_r];
    assign rd_resp_tag_o  = bypass_act ? tag_r         : tag_mem[rd_ptr_r];
    assign occupancy_o    = occ;

    // In-flight tracking. Reset clears inflight_r so stale RAM data
    // present after reset is never captured.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inflight_r <= 1'b0;
            tag_r      <= '0;
        end else begin
            inflight_r <= accept;
            if (accept) begin
                tag_r <= rd_req_tag_i;
            end
        end
    end

    // FIFO control
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_fifo) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop_fifo})
                2'b10:   count_r <= count_r + occ_width_lp'(1);
                2'b01:   count_r <= count_r - occ_width_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage has no reset; contents are qualified by count_r.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_r] <= ram_r0_data_i;
            tag_mem[wr_ptr_r]  <= tag_r;
        end
    end

    // Credit accounting makes this unreachable.
    overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && !pop_fifo && (count_r == fifo_els_lp)));

endmodule

// File: tb/tb_ram_rd_resp_stream.sv
module tb_ram_rd_resp_stream;

`ifdef RAM_RD_RESP_BYPASS_EN
    localparam int lat = 1;
`else
    localparam int lat = 2;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        rd_req_val_i = 1'b0;
    logic [8:0]  rd_req_addr_i = '0;
    logic [3:0]  rd_req_tag_i = '0;
    logic        rd_req_rdy_o;
    logic        ram_v0_o;
    logic        ram_w0_o;
    logic [8:0]  ram_addr0_o;
    logic [63:0] ram_r0_data_i = '0;
    logic        rd_resp_val_o;
    logic [63:0] rd_resp_data_o;
    logic [3:0]  rd_resp_tag_o;
    logic        rd_resp_rdy_i = 1'b0;
    logic [2:0]  occupancy_o;

    ram_rd_resp_stream dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .rd_req_val_i   (rd_req_val_i),
        .rd_req_addr_i  (rd_req_addr_i),
        .rd_req_tag_i   (rd_req_tag_i),
        .rd_req_rdy_o   (rd_req_rdy_o),
        .ram_v0_o       (ram_v0_o),
        .ram_w0_o       (ram_w0_o),
        .ram_addr0_o    (ram_addr0_o),
        .ram_r0_data_i  (ram_r0_data_i),
        .rd_resp_val_o  (rd_resp_val_o),
        .rd_resp_data_o (rd_resp_data_o),
        .rd_resp_tag_o  (rd_resp_tag_o),
        .rd_resp_rdy_i  (rd_resp_rdy_i),
        .occupancy_o    (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read RAM model, one cycle latency
    logic [63:0] ram_mem [512];
    always @(posedge clk_i) begin
        if (ram_v0_o && !ram_w0_o) ram_r0_data_i <= ram_mem[ram_addr0_o];
    end

    typedef struct {
        logic [63:0] d;
        logic [3:0]  t;
        int          n;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;

    // One cycle: drive inputs at negedge, sample at +2. Returns whether a
    // request was accepted / a response transferred, plus the reference
    // model's occupancy and expected response-valid before this cycle's edge.
    task automatic cyc(input bit v, input logic [8:0] a, input logic [3:0] t, input bit r,
                       output bit acc, output bit xfer, output int om, output bit vm);
        ent_t e;
        @(negedge clk_i);
        cyc_n++;
        rd_req_val_i  = v;
        rd_req_addr_i = a;
        rd_req_tag_i  = t;
        rd_resp_rdy_i = r;
        #2;
        om   = sb.size();
        vm   = (sb.size() > 0) && (cyc_n >= sb[0].n + lat);
        acc  = v && rd_req_rdy_o;
        xfer = rd_resp_val_o && r;
        if (acc) begin
            e.d = ram_mem[a];
            e.t = t;
            e.n = cyc_n;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        #1 reset_i = 1'b1;
        #1;
        checks++;
        if (rd_resp_val_o !== 1'b0) begin failures++; $display("FAIL reset_val: got %b expected 0", rd_resp_val_o); end
        checks++;
        if (occupancy_o !== 3'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occupancy_o); end
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        #2;
        checks++;
        if (rd_req_rdy_o !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b expected 1", rd_req_rdy_o); end
        checks++;
        if (ram_w0_o !== 1'b0) begin failures++; $display("FAIL reset_w0: got %b expected 0", ram_w0_o); end
    endtask

    task automatic test_single();
        bit acc, xfer, vm; int om; int got_at;
        ram_mem[16] = 64'hDEADBEEF_00000001;
        cyc(1, 9'h010, 4'h3, 1, acc, xfer, om, vm);
        checks++;
        if (ram_v0_o !== 1'b1 || ram_addr0_o !== 9'h010)
            begin failures++; $display("FAIL single_issue: got v=%b addr=%0h expected v=1 addr=10", ram_v0_o, ram_addr0_o); end
        got_at = -1;
        for (int k = 1; k <= 6 && got_at < 0; k++) begin
            cyc(0, 0, 0, 1, acc, xfer, om, vm);
            if (k == 1) begin
                checks++;
                if (ram_v0_o !== 1'b0) begin failures++; $display("FAIL single_v0_once: got %b expected 0", ram_v0_o); end
            end
            if (xfer) begin
                got_at = k;
                checks++;
                if (rd_resp_data_o !== 64'hDEADBEEF_00000001 || rd_resp_tag_o !== 4'h3)
                    begin failures++; $display("FAIL single_data: got %0h/%0h expected deadbeef00000001/3", rd_resp_data_o, rd_resp_tag_o); end
                void'(sb.pop_front());
            end
        end
        checks++;
        if (got_at != lat) begin failures++; $display("FAIL single_latency: got %0d expected %0d", got_at, lat); end
    endtask

    task automatic test_back_to_back();
        bit acc, xfer, vm; int om; int first, nresp;
        ent_t e;
        first = -1; nresp = 0;
        for (int k = 0; k < 20 && (k < 8 || sb.size() > 0); k++) begin
            cyc(k < 8, 9'(k), 4'(k), 1, acc, xfer, om, vm);
            if (k < 8) begin
                checks++;
                if (!acc) begin failures++; $display("FAIL b2b_rdy: cycle %0d got rdy=%b expected 1", k, rd_req_rdy_o); end
            end
            if (xfer) begin
                if (first < 0) first = k;
                e = sb.pop_front();
                checks++;
                if (rd_resp_data_o !== e.d || rd_resp_tag_o !== 4'(nresp) || k != first + nresp)
                    begin failures++; $display("FAIL b2b_resp: got %0h/%0h at %0d expected %0h/%0h at %0d",
                        rd_resp_data_o, rd_resp_tag_o, k, e.d, nresp, first + nresp); end
                nresp++;
            end
        end
        checks++;
        if (nresp != 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", nresp); end
    endtask

    task automatic drain(input string name);
        bit acc, xfer, vm; int om;
        ent_t e;
        for (int k = 0; k < 50 && sb.size() > 0; k++) begin
            cyc(0, 0, 0, 1, acc, xfer, om, vm);
            if (xfer) begin
                e = sb.pop_front();
                checks++;
                if (rd_resp_data_o !== e.d || rd_resp_tag_o !== e.t)
                    begin failures++; $display("FAIL %s_data: got %0h/%0h expected %0h/%0h", name, rd_resp_data_o, rd_resp_tag_o, e.d, e.t); end
            end
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL %s_drain: got %0d left expected 0", name, sb.size()); end
    endtask

    task automatic fill(output int nacc);
        bit acc, xfer, vm; int om;
        nacc = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1, 9'($urandom), 4'($urandom), 0, acc, xfer, om, vm);
            if (acc) nacc++;
        end
    endtask

    task automatic test_backpressure();
        bit acc, xfer, vm; int om; int nacc;
        fill(nacc);
        checks++;
        if (nacc != 4) begin failures++; $display("FAIL bp_accepts: got %0d expected 4", nacc); end
        checks++;
        if (rd_req_rdy_o !== 1'b0 || occupancy_o !== 3'd4 || ram_v0_o !== 1'b0)
            begin failures++; $display("FAIL bp_full: got rdy=%b occ=%0d v0=%b expected 0/4/0", rd_req_rdy_o, occupancy_o, ram_v0_o); end
        cyc(1, 9'h1ff, 4'hf, 1, acc, xfer, om, vm);
        checks++;
        if (!acc || !xfer) begin failures++; $display("FAIL bp_reaccept: got acc=%b xfer=%b expected 1/1", acc, xfer); end
        if (xfer) begin
            checks++;
            if (rd_resp_data_o !== sb[0].d || rd_resp_tag_o !== sb[0].t)
                begin failures++; $display("FAIL bp_head: got %0h expected %0h", rd_resp_data_o, sb[0].d); end
            void'(sb.pop_front());
        end
        drain("bp");
    endtask

    task automatic test_full_simul();
        bit acc, xfer, vm; int om; int nacc; int bad;
        ent_t e;
        fill(nacc);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 9'($urandom), 4'($urandom), 1, acc, xfer, om, vm);
            if (!acc || !xfer || occupancy_o !== 3'd4) bad++;
            if (xfer) begin
                e = sb.pop_front();
                checks++;
                if (rd_resp_data_o !== e.d || rd_resp_tag_o !== e.t)
                    begin failures++; $display("FAIL full_data: got %0h/%0h expected %0h/%0h", rd_resp_data_o, rd_resp_tag_o, e.d, e.t); end
            end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL full_simul: got %0d bad cycles expected 0", bad); end
        drain("full");
        cyc(0, 0, 0, 1, acc, xfer, om, vm);
        checks++;
        if (occupancy_o !== 3'd0) begin failures++; $display("FAIL full_occ_end: got %0d expected 0", occupancy_o); end
    endtask

    task automatic test_reset_mid();
        bit acc, xfer, vm; int om; int nacc; int seen;
        for (int k = 0; k < 5; k++) begin
            cyc(k < 4, 9'(k + 100), 4'(k), 0, acc, xfer, om, vm);
        end
        checks++;
        if (occupancy_o !== 3'd4 || rd_resp_val_o !== 1'b1)
            begin failures++; $display("FAIL rmid_pre: got occ=%0d val=%b expected 4/1", occupancy_o, rd_resp_val_o); end
        reset_i = 1'b1;
        #1;
        checks++;
        if (rd_resp_val_o !== 1'b0 || occupancy_o !== 3'd0)
            begin failures++; $display("FAIL rmid_async: got val=%b occ=%0d expected 0/0", rd_resp_val_o, occupancy_o); end
        sb.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 1, acc, xfer, om, vm);
            if (rd_resp_val_o !== 1'b0 || occupancy_o !== 3'd0) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL rmid_stale: got %0d cycles with output expected 0", seen); end
    endtask

    task automatic test_random();
        bit acc, xfer, vm, v, r; int om; int nacc; int bad_w0, bad_ctl;
        ent_t e;
        nacc = 0; bad_w0 = 0; bad_ctl = 0;
        for (int k = 0; k < 20000 && (nacc < 1000 || sb.size() > 0); k++) begin
            v = (nacc < 1000) && ($urandom_range(1) == 1);
            r = ($urandom_range(1) == 1);
            cyc(v, 9'($urandom), 4'($urandom), r, acc, xfer, om, vm);
            if (acc) nacc++;
            if (ram_w0_o !== 1'b0) bad_w0++;
            if (rd_resp_val_o !== vm || occupancy_o !== 3'(om) ||
                rd_req_rdy_o !== ((om < 4) || (om == 4 && vm && r)) ||
                ram_v0_o !== (v && rd_req_rdy_o)) begin
                bad_ctl++;
                if (bad_ctl <= 3) $display("FAIL rand_ctl: cycle %0d got val=%b occ=%0d rdy=%b expected val=%b occ=%0d",
                    k, rd_resp_val_o, occupancy_o, rd_req_rdy_o, vm, om);
            end
            if (xfer) begin
                e = sb.pop_front();
                checks++;
                if (rd_resp_data_o !== e.d || rd_resp_tag_o !== e.t)
                    begin failures++; $display("FAIL rand_data: got %0h/%0h expected %0h/%0h", rd_resp_data_o, rd_resp_tag_o, e.d, e.t); end
            end
        end
        checks++;
        if (bad_ctl != 0) begin failures++; $display("FAIL rand_ctl_total: got %0d bad cycles expected 0", bad_ctl); end
        checks++;
        if (bad_w0 != 0) begin failures++; $display("FAIL rand_w0: got %0d cycles with w0=1 expected 0", bad_w0); end
        checks++;
        if (nacc != 1000 || sb.size() != 0)
            begin failures++; $display("FAIL rand_complete: got %0d accepted %0d pending expected 1000/0", nacc, sb.size()); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram_mem[i] = {$urandom, $urandom};
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_rd_resp_stream.md
Name: ram_rd_resp_stream

Overview:
- Downstream companion to the banked 1RW+1W RAM wrapper.
- Accepts read requests on a valid/ready interface and drives the RAM's port-0 read signals (valid, write-enable, address).
- Captures the 1-cycle-latency synchronous read data, together with a caller tag, into a small response FIFO.
- Presents responses on a valid/ready stream. Credit accounting guarantees no read data is ever dropped; the RAM port has no backpressure.

Parameters:
- width_p, 64, RAM data width in bits.
- els_p, 512, RAM depth; addr_width_lp = `BSG_SAFE_CLOG2(els_p).
- tag_width_p, 4, width of the opaque tag carried with each request.
- fifo_els_p, 4, response FIFO depth; legal range 2..16.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- rd_req_val_i  in  1  read request valid
- rd_req_addr_i  in  addr_width_lp  read address
- rd_req_tag_i  in  tag_width_p  tag returned with the data
- rd_req_rdy_o  out  1  request accepted when val & rdy
- ram_v0_o  out  1  to RAM port-0 valid
- ram_w0_o  out  1  to RAM port-0 write enable; constant 0
- ram_addr0_o  out  addr_width_lp  to RAM port-0 address
- ram_r0_data_i  in  width_p  from RAM port-0 read data, valid 1 cycle after issue
- rd_resp_val_o  out  1  response valid
- rd_resp_data_o  out  width_p  response data
- rd_resp_tag_o  out  tag_width_p  response tag
- rd_resp_rdy_i  in  1  consumer ready; transfer on val & rdy
- occupancy_o  out  $clog2(fifo_els_p+1)  FIFO entries plus in-flight read

Behaviour:
- Interface decision: one clock, clk_i; reset_i is asynchronous and active-high.
- Reset values: rd_resp_val_o=0, occupancy_o=0, inflight_r=0, FIFO pointers=0, rd_req_rdy_o=1 once reset deasserts. Data and tag outputs are don't-care while val=0.
- Credits:
  - occ = fifo_count + inflight_r.
  - rd_req_rdy_o = (occ < fifo_els_p) | (occ == fifo_els_p & fifo_pop_this_cycle). Combinational from state and rd_resp_rdy_i only; never from rd_req_val_i.
- Issue path (combinational):
  - ram_v0_o = rd_req_val_i & rd_req_rdy_o.
  - ram_addr0_o = rd_req_addr_i.
  - ram_w0_o = 0.
- In-flight register:
  - On accept: inflight_r <= 1 and tag_r <= rd_req_tag_i; otherwise inflight_r <= 0.
  - At most one read is in flight per cycle; back-to-back accepts every cycle are legal.
- Capture:
  - When inflight_r=1, push {ram_r0_data_i, tag_r} into the FIFO at the clock edge.
  - ram_r0_data_i is ignored when inflight_r=0.
- FIFO:
  - Circular buffer with wr/rd pointers wrapping at fifo_els_p (not power-of-2 dependent) and a count register.
  - Push and pop in the same cycle are legal when full or empty: count unchanged, both pointers advance.
  - Overflow is impossible by construction; the model asserts on it.
- Output: rd_resp_val_o = (fifo_count != 0). Head entry is held stable until rd_resp_rdy_i.
- Latency: accept at cycle N → response valid at cycle N+2 (N+1 with the optional feature).
- Ordering: responses are strictly in request order.
- Reset mid-operation: in-flight read and all FIFO contents are discarded; the RAM's stale data is not captured after reset.

Optional Feature:
- Macro: RAM_RD_RESP_BYPASS_EN.
- Defined:
  - When fifo_count==0 and inflight_r==1, rd_resp_data_o/tag_o come directly from ram_r0_data_i/tag_r with rd_resp_val_o=1 in cycle N+1.
  - If rd_resp_rdy_i=1 that cycle, the push is suppressed; otherwise the entry is pushed normally.
  - rd_req_rdy_o also counts this bypass pop as fifo_pop_this_cycle.
- Undefined: all data passes through the FIFO; output is registered-only, latency 2.

Test Plan:
- Single read, addr 0x010 holding 0xDEADBEEF_00000001, tag 0x3, rdy_i=1 → ram_v0_o=1 one cycle; resp val at N+2 (N+1 with bypass), data 0xDEADBEEF_00000001, tag 0x3.
- 8 back-to-back reads to addrs 0..7, rdy_i=1 → rd_req_rdy_o stays 1; 8 responses in order, tags 0..7, one per cycle.
- rdy_i=0, stream reads → exactly 4 accepted (fifo_els_p=4), then rd_req_rdy_o=0, occupancy_o=4, ram_v0_o=0. Raise rdy_i → same-cycle re-accept; all data is intact.
- Full FIFO with rdy_i=1 and val_i=1 simultaneously → pop and accept in the same cycle; occupancy_o stays 4 and later returns to 0; wrap-around verified over 20 requests.
- Assert reset_i asynchronously with 1 in flight and 3 queued → rd_resp_val_o=0 immediately; after release occupancy_o=0, and the in-flight data never appears on the output.
- Random val/rdy (50%) over 1000 requests against a scoreboard → zero drops, zero reorders, ram_w0_o always 0.
